// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the store buffer: load/store width encodings,
// the buffered-store record, and helpers for width ranking and load extension.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Widest supported word address; narrower addresses are stored zero-extended.
  localparam int unsigned SB_ADDR_MAX = 64;

  typedef struct packed {
    logic [SB_ADDR_MAX-1:0] addr;
    logic [2:0]             funct3;
    logic [31:0]            data;
  } sb_entry_t;

  // Access size rank: 0 byte, 1 half, 2 word (signedness bit ignored).
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    logic [1:0] r;
    case (f3[1:0])
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{d[7]}}, d[7:0]};
      F3_H:    r = {{16{d[15]}}, d[15:0]};
      F3_BU:   r = {24'h000000, d[7:0]};
      F3_HU:   r = {16'h0000, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the store buffer's commit, load-lookup and memory-drain signals.
interface store_buffer_if #(parameter int AW = 32);

  logic          ROB_MemWrite;
  logic [AW-1:0] ROB_memadress;
  logic [2:0]    ROB_funct3;
  logic [31:0]   ROB_store_data;
  logic          sb_full;
  logic          sb_empty;
  logic          LS_MemRead;
  logic [AW-1:0] LS_result;
  logic [2:0]    func3_LS;
  logic          fwd_hit;
  logic          fwd_stall;
  logic [31:0]   fwd_data;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_wdata;
  logic          sb_overflow;

  modport master (
    output ROB_MemWrite, ROB_memadress, ROB_funct3, ROB_store_data,
    output LS_MemRead, LS_result, func3_LS, mem_ready,
    input  sb_full, sb_empty, fwd_hit, fwd_stall, fwd_data,
    input  mem_we, mem_addr, mem_funct3, mem_wdata, sb_overflow
  );

  modport slave (
    input  ROB_MemWrite, ROB_memadress, ROB_funct3, ROB_store_data,
    input  LS_MemRead, LS_result, func3_LS, mem_ready,
    output sb_full, sb_empty, fwd_hit, fwd_stall, fwd_data,
    output mem_we, mem_addr, mem_funct3, mem_wdata, sb_overflow
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-first address match over the store buffer entries; returns the
// matching record so the caller can decide between forwarding and stalling.
module sb_fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t              entries_i [DEPTH],
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [PW-1:0]          tail_i,
  input  logic [SB_ADDR_MAX-1:0] addr_i,
  output logic                   hit_o,
  output sb_entry_t              sel_o
);

  logic [PW-1:0] idx_s;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    idx_s = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx_s = tail_i - PW'(k + 1);
      if (valid_i[idx_s] && (entries_i[idx_s].addr == addr_i)) begin
        hit_o = 1'b1;
        sel_o = entries_i[idx_s];
      end else begin
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining to data memory, with load lookup.
// Store-to-load forwarding is built only when SB_FORWARD_EN is defined.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic          clk,
  input logic          reset,
  store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             full_s, empty_s, push_s, pop_s;
  logic             match_s;
  sb_entry_t        sel_s;
  logic [SB_ADDR_MAX-1:0] lookup_addr_s;

  // Next-state for pointers, occupancy, entries and the sticky overflow flag.
  always_comb begin
    full_s  = (count_q == (PW + 1)'(DEPTH));
    empty_s = (count_q == '0);
    pop_s   = !empty_s && sb.mem_ready;
    // A full buffer still takes a push when the head leaves in the same cycle.
    push_s  = sb.ROB_MemWrite && (!full_s || pop_s);

    entry_d = entry_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;

    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1'b1);
    end else begin
      head_d = head_q;
    end

    if (push_s) begin
      entry_d[tail_q].addr   = SB_ADDR_MAX'(sb.ROB_memadress);
      entry_d[tail_q].funct3 = sb.ROB_funct3;
      entry_d[tail_q].data   = sb.ROB_store_data;
      valid_d[tail_q]        = 1'b1;
      tail_d                 = tail_q + PW'(1'b1);
    end else begin
      ovf_d = ovf_q | sb.ROB_MemWrite;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW + 1)'(1'b1);
      2'b01:   count_d = count_q - (PW + 1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every buffered store immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Drain port and flags come straight from registered state.
  always_comb begin
    sb.mem_we      = !empty_s;
    sb.mem_addr    = entry_q[head_q].addr[AW-1:0];
    sb.mem_funct3  = entry_q[head_q].funct3;
    sb.mem_wdata   = entry_q[head_q].data;
    sb.sb_full     = full_s;
    sb.sb_empty    = empty_s;
    sb.sb_overflow = ovf_q;
  end

  assign lookup_addr_s = SB_ADDR_MAX'(sb.LS_result);

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .entries_i (entry_q),
    .valid_i   (valid_q),
    .tail_i    (tail_q),
    .addr_i    (lookup_addr_s),
    .hit_o     (match_s),
    .sel_o     (sel_s)
  );

`ifdef SB_FORWARD_EN
  // Forward only when the youngest matching store covers the whole load.
  always_comb begin
    sb.fwd_hit   = 1'b0;
    sb.fwd_stall = 1'b0;
    sb.fwd_data  = 32'h0000_0000;
    if (sb.LS_MemRead && match_s) begin
      if (f3_size(sel_s.funct3) >= f3_size(sb.func3_LS)) begin
        sb.fwd_hit  = 1'b1;
        sb.fwd_data = load_extend(sel_s.data, sb.func3_LS);
      end else begin
        sb.fwd_stall = 1'b1;
      end
    end else begin
      sb.fwd_hit = 1'b0;
    end
  end
`else
  // Without forwarding any address overlap makes the load retry.
  always_comb begin
    sb.fwd_hit   = 1'b0;
    sb.fwd_data  = 32'h0000_0000;
    sb.fwd_stall = sb.LS_MemRead && match_s;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed scoreboard bench for store_buffer: drain writes and load lookups are
// queued as expectations and compared by independent monitors.
module tb_store_buffer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(32)) sbif ();

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
  } drain_t;

  typedef struct packed {
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } fwd_t;

  drain_t drain_q[$];
  fwd_t   fwd_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drain monitor: every accepted memory write must match the oldest expected store.
  always @(negedge clk) begin
    drain_t e;
    if (reset === 1'b1 && sbif.mem_we === 1'b1 && sbif.mem_ready === 1'b1) begin
      if (drain_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_unexpected: got write to %h, expected none", sbif.mem_addr);
      end else begin
        e = drain_q.pop_front();
        check("drain_addr", sbif.mem_addr, e.addr);
        check("drain_f3", {29'd0, sbif.mem_funct3}, {29'd0, e.f3});
        check("drain_data", sbif.mem_wdata, e.data);
      end
    end
  end

  // Lookup monitor: every load lookup must match the queued forwarding result.
  always @(negedge clk) begin
    fwd_t f;
    if (reset === 1'b1 && sbif.LS_MemRead === 1'b1) begin
      if (fwd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fwd_unexpected: got lookup of %h, expected none", sbif.LS_result);
      end else begin
        f = fwd_q.pop_front();
        check("fwd_hit", {31'd0, sbif.fwd_hit}, {31'd0, f.hit});
        check("fwd_stall", {31'd0, sbif.fwd_stall}, {31'd0, f.stall});
        check("fwd_data", sbif.fwd_data, f.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sbif.ROB_MemWrite   = 1'b0;
    sbif.ROB_memadress  = 32'h0;
    sbif.ROB_funct3     = 3'b000;
    sbif.ROB_store_data = 32'h0;
    sbif.LS_MemRead     = 1'b0;
    sbif.LS_result      = 32'h0;
    sbif.func3_LS       = 3'b000;
    sbif.mem_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    drain_q.delete();
    fwd_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                      input bit accepted);
    sbif.ROB_MemWrite   = 1'b1;
    sbif.ROB_memadress  = a;
    sbif.ROB_funct3     = f3;
    sbif.ROB_store_data = d;
    if (accepted) drain_q.push_back(drain_t'{addr: a, f3: f3, data: d});
    tick();
    sbif.ROB_MemWrite = 1'b0;
  endtask

  // match: an older valid store hits this address; ok/fdata: forward-build outcome.
  task automatic lookup(input logic [31:0] a, input logic [2:0] f3, input bit match,
                        input bit ok, input logic [31:0] fdata);
    fwd_t e;
`ifdef SB_FORWARD_EN
    e.hit   = match && ok;
    e.stall = match && !ok;
    e.data  = (match && ok) ? fdata : 32'h0;
`else
    e.hit   = 1'b0;
    e.stall = match;
    e.data  = 32'h0;
`endif
    sbif.LS_MemRead = 1'b1;
    sbif.LS_result  = a;
    sbif.func3_LS   = f3;
    fwd_q.push_back(e);
    tick();
    sbif.LS_MemRead = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mem_we", {31'd0, sbif.mem_we}, 32'd0);
    check("rst_empty", {31'd0, sbif.sb_empty}, 32'd1);
    check("rst_full", {31'd0, sbif.sb_full}, 32'd0);
    check("rst_overflow", {31'd0, sbif.sb_overflow}, 32'd0);
    check("rst_fwd", {30'd0, sbif.fwd_hit, sbif.fwd_stall}, 32'd0);
    tick();
    reset = 1'b1;

    // Single store, drained as soon as it is visible.
    sbif.mem_ready      = 1'b1;
    sbif.ROB_MemWrite   = 1'b1;
    sbif.ROB_memadress  = 32'h10;
    sbif.ROB_funct3     = F3_W;
    sbif.ROB_store_data = 32'hDEAD_BEEF;
    drain_q.push_back(drain_t'{addr: 32'h10, f3: F3_W, data: 32'hDEAD_BEEF});
    #1;
    check("push_latency_we", {31'd0, sbif.mem_we}, 32'd0);
    tick();
    sbif.ROB_MemWrite = 1'b0;
    check("single_we", {31'd0, sbif.mem_we}, 32'd1);
    tick();
    check("single_empty", {31'd0, sbif.sb_empty}, 32'd1);

    // Overflow: fifth push into a full, stalled buffer is dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) push(32'(i), F3_W, 32'h100 + 32'(i), i <= 4);
    check("ovf_full", {31'd0, sbif.sb_full}, 32'd1);
    check("ovf_flag", {31'd0, sbif.sb_overflow}, 32'd1);
    check("ovf_head_hold", sbif.mem_addr, 32'd1);
    sbif.mem_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", {31'd0, sbif.sb_empty}, 32'd1);
    check("ovf_sticky", {31'd0, sbif.sb_overflow}, 32'd1);
    sbif.mem_ready = 1'b0;

    // Push and pop together at full and at one entry, across pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i), F3_W, 32'hA0 + 32'(i), 1'b1);
    sbif.mem_ready = 1'b1;
    push(32'h204, F3_H, 32'hA4, 1'b1);
    check("pp_full_a", {31'd0, sbif.sb_full}, 32'd1);
    push(32'h205, F3_B, 32'hA5, 1'b1);
    check("pp_full_b", {31'd0, sbif.sb_full}, 32'd1);
    check("pp_no_ovf", {31'd0, sbif.sb_overflow}, 32'd0);
    repeat (4) tick();
    check("pp_empty", {31'd0, sbif.sb_empty}, 32'd1);
    push(32'h300, F3_W, 32'h11, 1'b1);
    push(32'h301, F3_W, 32'h22, 1'b1);
    check("pp_one_we", {31'd0, sbif.mem_we}, 32'd1);
    check("pp_one_addr", sbif.mem_addr, 32'h301);
    tick();
    check("pp_one_empty", {31'd0, sbif.sb_empty}, 32'd1);
    sbif.mem_ready = 1'b0;

    // Byte loads from a buffered word, misses and same-cycle push invisibility.
    do_reset();
    push(32'h20, F3_W, 32'h0000_00F0, 1'b1);
    lookup(32'h20, F3_B, 1'b1, 1'b1, 32'hFFFF_FFF0);
    lookup(32'h20, F3_BU, 1'b1, 1'b1, 32'h0000_00F0);
    lookup(32'h24, F3_W, 1'b0, 1'b0, 32'h0);
    sbif.LS_result = 32'h20;
    sbif.func3_LS  = F3_W;
    #1;
    check("noread_fwd", {30'd0, sbif.fwd_hit, sbif.fwd_stall}, 32'd0);
    check("noread_data", sbif.fwd_data, 32'h0);
    sbif.ROB_MemWrite   = 1'b1;
    sbif.ROB_memadress  = 32'h40;
    sbif.ROB_funct3     = F3_W;
    sbif.ROB_store_data = 32'h55;
    drain_q.push_back(drain_t'{addr: 32'h40, f3: F3_W, data: 32'h55});
    lookup(32'h40, F3_W, 1'b0, 1'b0, 32'h0);
    sbif.ROB_MemWrite = 1'b0;
    lookup(32'h40, F3_W, 1'b1, 1'b1, 32'h55);
    sbif.mem_ready = 1'b1;
    repeat (2) tick();
    sbif.mem_ready = 1'b0;

    // Narrow store vs wider loads, youngest-match priority, halfword extension.
    do_reset();
    push(32'h30, F3_B, 32'h1234, 1'b1);
    lookup(32'h30, F3_W, 1'b1, 1'b0, 32'h0);
    lookup(32'h30, F3_H, 1'b1, 1'b0, 32'h0);
    lookup(32'h30, F3_B, 1'b1, 1'b1, 32'h34);
    push(32'h30, F3_W, 32'h1, 1'b1);
    push(32'h30, F3_W, 32'h2, 1'b1);
    lookup(32'h30, F3_W, 1'b1, 1'b1, 32'h2);
    push(32'h50, F3_W, 32'h0000_8001, 1'b1);
    lookup(32'h50, F3_H, 1'b1, 1'b1, 32'hFFFF_8001);
    lookup(32'h50, F3_HU, 1'b1, 1'b1, 32'h0000_8001);

    // An entry leaving this cycle still answers this cycle's lookup.
    do_reset();
    push(32'h60, F3_W, 32'h7, 1'b1);
    sbif.mem_ready = 1'b1;
    lookup(32'h60, F3_W, 1'b1, 1'b1, 32'h7);
    check("popfwd_empty", {31'd0, sbif.sb_empty}, 32'd1);
    lookup(32'h60, F3_W, 1'b0, 1'b0, 32'h0);
    sbif.mem_ready = 1'b0;

    // Reset while draining with three stores outstanding.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h70 + 32'(i), F3_W, 32'hC0 + 32'(i), 1'b1);
    sbif.mem_ready = 1'b1;
    tick();
    check("mid_we_before", {31'd0, sbif.mem_we}, 32'd1);
    check("mid_head", sbif.mem_addr, 32'h71);
    reset = 1'b0;
    drain_q.delete();
    #1;
    check("mid_rst_we", {31'd0, sbif.mem_we}, 32'd0);
    check("mid_rst_empty", {31'd0, sbif.sb_empty}, 32'd1);
    check("mid_rst_full", {31'd0, sbif.sb_full}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_after_we", {31'd0, sbif.mem_we}, 32'd0);
    check("mid_after_empty", {31'd0, sbif.sb_empty}, 32'd1);
    sbif.mem_ready = 1'b0;
    tick();

    check("drain_leftover", 32'(drain_q.size()), 32'd0);
    check("fwd_leftover", 32'(fwd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered committed stores (power of 2, minimum 2).
REQ-002 SHALL have parameter AW, default 32, meaning the word-address width.
REQ-003 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ROB_MemWrite  in  1  commit push of one store.
REQ-006 SHALL have port ROB_memadress  in  AW  word address of the committed store.
REQ-007 SHALL have port ROB_funct3  in  3  store width: 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port ROB_store_data  in  32  store data, LSB-aligned.
REQ-009 SHALL have port sb_full / sb_empty  out  1 each  occupancy flags.
REQ-010 SHALL have port LS_MemRead  in  1  load lookup valid.
REQ-011 SHALL have port LS_result / func3_LS  in  AW / 3  load word address / load width.
REQ-012 SHALL have port fwd_hit / fwd_stall  out  1 each  forward valid / load must retry.
REQ-013 SHALL have port fwd_data  out  32  forwarded, extended load data.
REQ-014 SHALL have port mem_we / mem_ready  out / in  1 each  drain write request / memory accept.
REQ-015 SHALL have port mem_addr / mem_funct3 / mem_wdata  out  AW / 3 / 32  head entry toward data memory.
REQ-016 SHALL have port sb_overflow  out  1  sticky; set when a push is dropped.

Function
REQ-017 SHALL be a circular FIFO with head/tail pointers of width log2(DEPTH) that wrap from DEPTH-1 to 0, plus a count of width log2(DEPTH)+1.
REQ-018 SHALL accept a push on a clk edge when ROB_MemWrite=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-019 SHALL drop a push when full with no same-cycle pop, leave all state unchanged, and set sb_overflow.
REQ-020 SHALL drive mem_we=1 whenever count>0, with mem_addr/mem_funct3/mem_wdata equal to the head entry (combinational from registers).
REQ-021 SHALL pop the head on a clk edge where mem_we=1 and mem_ready=1, and SHALL hold the head stable while mem_ready=0.
REQ-022 SHALL NOT present a pushed entry on the mem_* outputs before the cycle after its push (minimum 1-cycle latency).
REQ-023 SHALL perform a simultaneous push and pop with count unchanged, including at count=DEPTH and count=1.
REQ-024 SHALL assert sb_full when count=DEPTH and sb_empty when count=0.
REQ-025 SHALL drive fwd_hit=0, fwd_stall=0 and fwd_data=0 when LS_MemRead=0 or no valid entry matches LS_result.
REQ-026 SHALL evaluate forwarding combinationally against the youngest valid matching entry.
REQ-027 SHALL forward (fwd_hit=1) when that entry's width is greater than or equal to the load width (LB/LBU ≤ all, LH/LHU ≤ SH/SW, LW ≤ SW); otherwise fwd_stall=1 and fwd_hit=0.
REQ-028 SHALL extend fwd_data per func3_LS: LB sign-extended from bit 7, LH sign-extended from bit 15, LW full word, LBU/LHU zero-extended.
REQ-029 SHALL treat an entry popping in the same cycle as still valid for that cycle's lookup.
REQ-030 SHALL treat a same-cycle push as invisible to that cycle's lookup.

Reset
REQ-031 SHALL, while reset=0, clear head, tail, count, all valid bits and sb_overflow immediately; mem_we=0, sb_empty=1, sb_full=0.
REQ-032 SHALL discard buffered entries on a reset assertion mid-drain, with no further mem_we.

Configuration
REQ-033 SHALL, when SB_FORWARD_EN is defined, implement REQ-026..REQ-030.
REQ-034 SHALL, when SB_FORWARD_EN is undefined, tie fwd_hit=0 and fwd_data=0, and assert fwd_stall=1 whenever LS_MemRead=1 and any valid entry address-matches.

Structure
REQ-035 SHALL take funct3 load/store encodings and the entry record (addr, funct3, data) from the shared package cpu_pkg.
REQ-036 SHALL implement the youngest-match priority search in one sub-module, sb_fwd_match.

Verification
REQ-037 SHALL verify: push SW 0x10/0xDEADBEEF with mem_ready=1 -> mem_we=1 next cycle with addr 0x10, pop, sb_empty=1.
REQ-038 SHALL verify: 5 pushes with DEPTH=4 and mem_ready=0 -> sb_full=1, 5th dropped, sb_overflow=1, drain order 1..4.
REQ-039 SHALL verify: SW 0x20=0x000000F0 buffered, LB 0x20 -> fwd_hit=1, fwd_data=0xFFFFFFF0; LBU -> 0x000000F0.
REQ-040 SHALL verify: SB 0x30 buffered, LW 0x30 -> fwd_stall=1 (forward build); SW 0x30=1 then SW 0x30=2, LW -> fwd_data=2.
REQ-041 SHALL verify: full buffer with push and pop in the same cycle -> count stays 4, no overflow, wrap-around order preserved.
REQ-042 SHALL verify: reset asserted mid-drain with count=3 -> mem_we=0 immediately, sb_empty=1.
